// File: rtl/mem_addr_unit.sv
// EDiC memory-addressing unit: PC, SP, MAR and instruction register, data-address decode
// into RAM / stack page / I/O page, data-bus source mux, stack fault and breakpoint tracking.
module mem_addr_unit #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned ROM_AW     = 15,
  parameter int unsigned SP_W       = 8,
  parameter logic [7:0]  STACK_PAGE = 8'hFF,
  parameter logic [7:0]  IO_PAGE    = 8'hFE,
  parameter int unsigned BP_COUNT   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_bus,
  output logic [7:0]             o_bus,
  output logic                   o_busNOE,
  input  logic                   i_ctrlPCLoadN,
  input  logic                   i_ctrlPCNEn,
  input  logic                   i_ctrlPCFromImm,
  input  logic                   i_ctrlPCToBusN,
  input  logic                   i_ctrlSpUp,
  input  logic                   i_ctrlSpNEn,
  input  logic                   i_ctrlInstrNWE,
  input  logic                   i_ctrlInstrNOE,
  input  logic                   i_ctrlRamNOE,
  input  logic                   i_ctrlRamNWE,
  input  logic                   i_ctrlMar0NWE,
  input  logic                   i_ctrlMar1NWE,
  input  logic                   i_ctrlMarInc,
  input  logic                   i_ctrlImmToRamAddr,
  input  logic                   i_faultClr,
  input  logic                   i_halt,
  output logic [ROM_AW-1:0]      o_romAddress,
  input  logic [23:0]            i_romData,
  output logic [7:0]             o_instrCode,
  output logic [16:0]            o_ramAddress,
  input  logic [7:0]             i_ramData,
  input  logic [7:0]             i_ram2Data,
  output logic [7:0]             o_ramData,
  output logic [7:0]             o_ram2Data,
  output logic                   o_ramWE,
  output logic                   o_ramCE,
  output logic                   o_ioSelect,
  output logic [7:0]             o_ioAddress,
  output logic                   o_ioNOE,
  output logic                   o_ioNWE,
  input  logic [16*BP_COUNT-1:0] i_bpAddress,
  input  logic [BP_COUNT-1:0]    i_bpEnableN,
  output logic [BP_COUNT-1:0]    o_bpHitN,
  output logic [BP_COUNT-1:0]    o_bpLatched,
  output logic                   o_stackOvf,
  output logic                   o_stackUnf,
  output logic [15:0]            o_dbgPc,
  output logic [SP_W-1:0]        o_dbgSp
);

  localparam logic [SP_W-1:0] SpMax = '1;

  logic [PC_W-1:0]     pcQ, pcD;
  logic [SP_W-1:0]     spQ, spD;
  logic [15:0]         marQ, marD;
  logic [7:0]          opQ, opD;
  logic [15:0]         immQ, immD;
  logic                ovfQ, ovfD, unfQ, unfD;
  logic [BP_COUNT-1:0] bpLatQ, bpLatD;

  logic [15:0] pc16;
  logic [15:0] pcSrc;
  logic [7:0]  spExt;
  logic [15:0] sel;
  logic        stackSel;
  logic        spStep, ovfSet, unfSet;

  assign pc16  = 16'(pcQ);
  assign spExt = 8'(spQ);
  assign pcSrc = i_ctrlPCFromImm ? immQ : {i_ram2Data, i_bus};

  // Data-address decode
  assign sel          = i_ctrlImmToRamAddr ? immQ : marQ;
  assign stackSel     = (sel[15:8] == STACK_PAGE);
  assign o_ioSelect   = (sel[15:8] == IO_PAGE);
  assign o_ioAddress  = sel[7:0];
  assign o_ramAddress = {stackSel, (stackSel ? spExt : sel[15:8]), sel[7:0]};
  assign o_ramCE      = ~o_ioSelect;
  assign o_ramWE      = ~i_ctrlRamNWE;
  assign o_ioNOE      = i_ctrlRamNOE;
  assign o_ioNWE      = i_ctrlRamNWE;
  assign o_ramData    = i_bus;
  assign o_ram2Data   = pc16[15:8];

  assign o_romAddress = pc16[ROM_AW-1:0];
  assign o_instrCode  = opQ;
  assign o_stackOvf   = ovfQ;
  assign o_stackUnf   = unfQ;
  assign o_bpLatched  = bpLatQ;
  assign o_dbgPc      = pc16;
  assign o_dbgSp      = spQ;

  always_comb begin
    o_bus    = 8'h00;
    o_busNOE = 1'b1;
    if (!i_ctrlInstrNOE) begin
      o_bus    = immQ[7:0];
      o_busNOE = 1'b0;
    end else if (!i_ctrlPCToBusN) begin
      o_bus    = pc16[7:0];
      o_busNOE = 1'b0;
    end else if (!i_ctrlRamNOE && o_ramCE) begin
      o_bus    = i_ramData;
      o_busNOE = 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < BP_COUNT; k++) begin
      o_bpHitN[k] = ~(~i_bpEnableN[k] & (pc16 == i_bpAddress[16*k +: 16]));
    end
  end

  always_comb begin
    pcD = pcQ;
    if (!i_ctrlPCLoadN) begin
      pcD = PC_W'(pcSrc);
    end else if (!i_ctrlPCNEn && !i_halt) begin
      pcD = pcQ + PC_W'(1);
    end

    // SP saturates at either end and flags the attempted step instead of wrapping
    spStep = !i_ctrlSpNEn && !i_halt;
    ovfSet = spStep && i_ctrlSpUp && (spQ == SpMax);
    unfSet = spStep && !i_ctrlSpUp && (spQ == '0);
    spD    = spQ;
    if (spStep && !ovfSet && !unfSet) begin
      spD = i_ctrlSpUp ? spQ + SP_W'(1) : spQ - SP_W'(1);
    end
    ovfD = (ovfQ && !i_faultClr) || ovfSet;
    unfD = (unfQ && !i_faultClr) || unfSet;

    marD = marQ;
    if (!i_ctrlMar0NWE || !i_ctrlMar1NWE) begin
      if (!i_ctrlMar0NWE) marD[7:0]  = i_bus;
      if (!i_ctrlMar1NWE) marD[15:8] = i_bus;
    end else if (i_ctrlMarInc) begin
      marD = marQ + 16'd1;
    end

    opD  = opQ;
    immD = immQ;
    if (!i_ctrlInstrNWE) begin
      opD  = i_romData[23:16];
      immD = i_romData[15:0];
    end

    bpLatD = bpLatQ | ~o_bpHitN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pcQ    <= '0;
      spQ    <= '0;
      marQ   <= '0;
      opQ    <= '0;
      immQ   <= '0;
      ovfQ   <= 1'b0;
      unfQ   <= 1'b0;
      bpLatQ <= '0;
    end else begin
      pcQ    <= pcD;
      spQ    <= spD;
      marQ   <= marD;
      opQ    <= opD;
      immQ   <= immD;
      ovfQ   <= ovfD;
      unfQ   <= unfD;
      bpLatQ <= bpLatD;
    end
  end

endmodule

// File: tb/tb_mem_addr_unit.sv
// Randomized plus directed bench for mem_addr_unit: a driver pushes predicted outputs into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_mem_addr_unit;

  localparam int SpMax = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pcLoadN, pcNEn, pcFromImm, pcToBusN, spUp, spNEn, instrNWE, instrNOE;
  logic        ramNOE, ramNWE, mar0NWE, mar1NWE, marInc, immToRamAddr, faultClr, halt;
  logic [7:0]  busIn, busOut, instrCode, ramDataIn, ram2DataIn, ramDataOut, ram2DataOut;
  logic [7:0]  ioAddress, dbgSp;
  logic        busNOE, ramWE, ramCE, ioSelect, ioNOE, ioNWE, stackOvf, stackUnf;
  logic [14:0] romAddress;
  logic [23:0] romData;
  logic [16:0] ramAddress;
  logic [31:0] bpAddress;
  logic [1:0]  bpEnableN, bpHitN, bpLatched;
  logic [15:0] dbgPc;

  mem_addr_unit dut (
    .i_clk(clk), .i_reset(reset), .i_bus(busIn), .o_bus(busOut), .o_busNOE(busNOE),
    .i_ctrlPCLoadN(pcLoadN), .i_ctrlPCNEn(pcNEn), .i_ctrlPCFromImm(pcFromImm),
    .i_ctrlPCToBusN(pcToBusN), .i_ctrlSpUp(spUp), .i_ctrlSpNEn(spNEn),
    .i_ctrlInstrNWE(instrNWE), .i_ctrlInstrNOE(instrNOE), .i_ctrlRamNOE(ramNOE),
    .i_ctrlRamNWE(ramNWE), .i_ctrlMar0NWE(mar0NWE), .i_ctrlMar1NWE(mar1NWE),
    .i_ctrlMarInc(marInc), .i_ctrlImmToRamAddr(immToRamAddr), .i_faultClr(faultClr),
    .i_halt(halt), .o_romAddress(romAddress), .i_romData(romData), .o_instrCode(instrCode),
    .o_ramAddress(ramAddress), .i_ramData(ramDataIn), .i_ram2Data(ram2DataIn),
    .o_ramData(ramDataOut), .o_ram2Data(ram2DataOut), .o_ramWE(ramWE), .o_ramCE(ramCE),
    .o_ioSelect(ioSelect), .o_ioAddress(ioAddress), .o_ioNOE(ioNOE), .o_ioNWE(ioNWE),
    .i_bpAddress(bpAddress), .i_bpEnableN(bpEnableN), .o_bpHitN(bpHitN),
    .o_bpLatched(bpLatched), .o_stackOvf(stackOvf), .o_stackUnf(stackUnf),
    .o_dbgPc(dbgPc), .o_dbgSp(dbgSp)
  );

  typedef struct {
    bit reset, pcLoadN, pcNEn, pcFromImm, pcToBusN, spUp, spNEn, instrNWE, instrNOE;
    bit ramNOE, ramNWE, mar0NWE, mar1NWE, marInc, immToRamAddr, faultClr, halt;
    bit [7:0] bus, ramData, ram2Data;
    bit [23:0] romData;
    bit [31:0] bpAddress;
    bit [1:0] bpEnableN;
  } stim_t;

  typedef struct {
    int romAddr, ramAddr, bus, busNOE, ioSel, ioAddr, ramCE, instr, hitN, lat;
    int ovf, unf, pc, sp, ram2, ramWE;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state as plain integers
  int mPc, mSp, mMar, mOp, mImm, mOvf, mUnf, mLat;
  bit mValid = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hitsN(input stim_t s);
    int h = 0;
    for (int k = 0; k < 2; k++) begin
      int addr = int'((s.bpAddress >> (16 * k)) & 32'hFFFF);
      if (!(s.bpEnableN[k] == 1'b0 && mPc == addr)) h += (1 << k);
    end
    return h;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    int sel = s.immToRamAddr ? mImm : mMar;
    int hi = sel / 256;
    int lo = sel % 256;
    int stk = (hi == 255) ? 1 : 0;
    e.ioSel   = (hi == 254) ? 1 : 0;
    e.ioAddr  = lo;
    e.ramCE   = 1 - e.ioSel;
    e.ramAddr = stk * 65536 + (stk ? mSp : hi) * 256 + lo;
    e.busNOE  = 0;
    if (!s.instrNOE) e.bus = mImm % 256;
    else if (!s.pcToBusN) e.bus = mPc % 256;
    else if (!s.ramNOE && e.ramCE == 1) e.bus = s.ramData;
    else begin
      e.bus    = 0;
      e.busNOE = 1;
    end
    e.romAddr = mPc % 32768;
    e.instr   = mOp;
    e.hitN    = hitsN(s);
    e.lat     = mLat;
    e.ovf     = mOvf;
    e.unf     = mUnf;
    e.pc      = mPc;
    e.sp      = mSp;
    e.ram2    = mPc / 256;
    e.ramWE   = s.ramNWE ? 0 : 1;
    return e;
  endfunction

  task automatic modelStep(input stim_t s);
    int hn;
    bit stepSp;
    if (s.reset) begin
      {mPc, mSp, mMar, mOp, mImm, mOvf, mUnf, mLat} = '0;
      mValid = 1;
      return;
    end
    hn = hitsN(s);
    mLat = mLat | (~hn & 3);
    if (!s.pcLoadN) mPc = s.pcFromImm ? mImm : (s.ram2Data * 256 + s.bus);
    else if (!s.pcNEn && !s.halt) mPc = (mPc + 1) % 65536;
    if (s.faultClr) begin
      mOvf = 0;
      mUnf = 0;
    end
    stepSp = !s.spNEn && !s.halt;
    if (stepSp && s.spUp) begin
      if (mSp == SpMax) mOvf = 1;
      else mSp++;
    end else if (stepSp) begin
      if (mSp == 0) mUnf = 1;
      else mSp--;
    end
    if (!s.mar0NWE || !s.mar1NWE) begin
      if (!s.mar0NWE) mMar = (mMar / 256) * 256 + s.bus;
      if (!s.mar1NWE) mMar = s.bus * 256 + (mMar % 256);
    end else if (s.marInc) mMar = (mMar + 1) % 65536;
    if (!s.instrNWE) begin
      mOp  = int'(s.romData[23:16]);
      mImm = int'(s.romData[15:0]);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    {s.pcLoadN, s.pcNEn, s.pcToBusN, s.spNEn, s.instrNWE, s.instrNOE} = '1;
    {s.ramNOE, s.ramNWE, s.mar0NWE, s.mar1NWE} = '1;
    s.bpEnableN = 2'b11;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.reset; pcLoadN = s.pcLoadN; pcNEn = s.pcNEn; pcFromImm = s.pcFromImm;
    pcToBusN = s.pcToBusN; spUp = s.spUp; spNEn = s.spNEn; instrNWE = s.instrNWE;
    instrNOE = s.instrNOE; ramNOE = s.ramNOE; ramNWE = s.ramNWE; mar0NWE = s.mar0NWE;
    mar1NWE = s.mar1NWE; marInc = s.marInc; immToRamAddr = s.immToRamAddr;
    faultClr = s.faultClr; halt = s.halt; busIn = s.bus; ramDataIn = s.ramData;
    ram2DataIn = s.ram2Data; romData = s.romData; bpAddress = s.bpAddress;
    bpEnableN = s.bpEnableN;
  endtask

  stim_t prev;
  bit havePrev = 0;

  // One cycle: retire the previous cycle into the model, then apply and predict this one
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    if (havePrev) modelStep(prev);
    apply(s);
    if (mValid) sb.push_back(predict(s));
    prev = s;
    havePrev = 1;
  endtask

  function automatic bit actN(input int pct);
    return ($urandom_range(99) < pct) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit [7:0] pickByte();
    case ($urandom_range(3))
      0: return 8'hFF;
      1: return 8'hFE;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic stim_t randStim();
    stim_t s = idle();
    s.reset        = ($urandom_range(99) < 2);
    s.pcLoadN      = actN(8);
    s.pcNEn        = actN(60);
    s.pcFromImm    = 1'($urandom);
    s.pcToBusN     = actN(20);
    s.spUp         = 1'($urandom);
    s.spNEn        = actN(40);
    s.instrNWE     = actN(30);
    s.instrNOE     = actN(20);
    s.ramNOE       = actN(50);
    s.ramNWE       = actN(30);
    s.mar0NWE      = actN(20);
    s.mar1NWE      = actN(20);
    s.marInc       = ($urandom_range(99) < 40);
    s.immToRamAddr = 1'($urandom);
    s.faultClr     = ($urandom_range(99) < 10);
    s.halt         = ($urandom_range(99) < 15);
    s.bus          = pickByte();
    s.ramData      = 8'($urandom);
    s.ram2Data     = 8'($urandom);
    s.romData      = {8'($urandom), pickByte(), 8'($urandom)};
    s.bpAddress    = {16'(mPc + $urandom_range(2)), 16'(mPc + $urandom_range(3))};
    s.bpEnableN    = 2'($urandom);
    return s;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("romAddress", 32'(romAddress), e.romAddr);
        chk("ramAddress", 32'(ramAddress), e.ramAddr);
        chk("bus", 32'(busOut), e.bus);
        chk("busNOE", 32'(busNOE), e.busNOE);
        chk("ioSelect", 32'(ioSelect), e.ioSel);
        chk("ioAddress", 32'(ioAddress), e.ioAddr);
        chk("ramCE", 32'(ramCE), e.ramCE);
        chk("ramWE", 32'(ramWE), e.ramWE);
        chk("instrCode", 32'(instrCode), e.instr);
        chk("bpHitN", 32'(bpHitN), e.hitN);
        chk("bpLatched", 32'(bpLatched), e.lat);
        chk("stackOvf", 32'(stackOvf), e.ovf);
        chk("stackUnf", 32'(stackUnf), e.unf);
        chk("dbgPc", 32'(dbgPc), e.pc);
        chk("dbgSp", 32'(dbgSp), e.sp);
        chk("ram2Data", 32'(ram2DataOut), e.ram2);
        chk("ramData", 32'(ramDataOut), int'(busIn));
        chk("ioStrobes", 32'({ioNOE, ioNWE}), int'({ramNOE, ramNWE}));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1;
    apply(s);
    drive(s);

    // PC count, halt, then load from immediate while halted
    s = idle(); s.pcNEn = 0;
    repeat (3) drive(s);
    s.halt = 1;
    repeat (2) drive(s);
    s = idle(); s.instrNWE = 0; s.romData = 24'hA51234;
    drive(s);
    s = idle(); s.pcLoadN = 0; s.pcFromImm = 1; s.halt = 1; s.pcNEn = 0;
    drive(s);
    drive(idle());

    // Underflow, clear colliding with a fresh underflow, clear alone, then overflow
    s = idle(); s.reset = 1; drive(s);
    s = idle(); s.spNEn = 0; drive(s);
    s.faultClr = 1; drive(s);
    s = idle(); s.faultClr = 1; drive(s);
    s = idle(); s.spNEn = 0; s.spUp = 1;
    repeat (257) drive(s);
    s = idle(); s.immToRamAddr = 1; drive(s);

    // MAR carry, wrap, and write-beats-increment
    s = idle(); s.mar1NWE = 0; s.bus = 8'h00; drive(s);
    s = idle(); s.mar0NWE = 0; s.bus = 8'hFF; drive(s);
    s = idle(); s.marInc = 1; drive(s);
    s = idle(); s.mar1NWE = 0; s.mar0NWE = 0; s.bus = 8'hFF; drive(s);
    s = idle(); s.marInc = 1; drive(s);
    s = idle(); s.mar0NWE = 0; s.marInc = 1; s.bus = 8'h55; drive(s);
    drive(idle());

    // Stack-page and I/O-page decode
    s = idle(); s.reset = 1; drive(s);
    s = idle(); s.spNEn = 0; s.spUp = 1;
    repeat (7) drive(s);
    s = idle(); s.mar1NWE = 0; s.mar0NWE = 0; s.bus = 8'hFF; drive(s);
    s = idle(); s.mar0NWE = 0; s.bus = 8'h10; drive(s);
    s = idle(); s.ramNOE = 0; s.ramData = 8'h3C; drive(s);
    s = idle(); s.mar1NWE = 0; s.mar0NWE = 0; s.bus = 8'hFE; drive(s);
    s = idle(); s.mar0NWE = 0; s.bus = 8'h20; drive(s);
    s = idle(); s.ramNOE = 0; s.ramData = 8'hC3; drive(s);

    // Breakpoints: ch0 enabled, ch1 disabled, both at 5
    s = idle(); s.reset = 1; drive(s);
    s = idle(); s.pcNEn = 0; s.bpAddress = 32'h0005_0005; s.bpEnableN = 2'b10;
    repeat (8) drive(s);
    s.reset = 1; drive(s);
    s.reset = 0; s.pcNEn = 1; drive(s);

    // Bus priority
    s = idle(); s.instrNWE = 0; s.romData = 24'h0077AB; drive(s);
    s = idle(); s.instrNOE = 0; s.pcToBusN = 0; s.ramNOE = 0; drive(s);
    s = idle(); s.pcToBusN = 0; s.ramNOE = 0; drive(s);
    drive(idle());

    repeat (2000) drive(randStim());
    drive(idle());

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
